// File: rtl/irq_timer.sv
// irq_timer: memory-mapped countdown timer used as a CP0 hardware interrupt source (one-shot / periodic).
// Defining IRQ_TIMER_PRESCALE_EN adds a CTRL[7:4] prescaler that stretches each COUNT step to PS+1 cycles.
module irq_timer #(
   parameter int COUNT_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  Addr,
   input  logic        WE,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        IRQ
);

`ifdef IRQ_TIMER_PRESCALE_EN
   localparam int CTRL_W = 8;
`else
   localparam int CTRL_W = 4;
`endif
   localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
   localparam logic [COUNT_W-1:0] CNT_ZERO = COUNT_W'(0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
   logic [COUNT_W-1:0]  preset_q, preset_d;
   logic [COUNT_W-1:0]  count_q, count_d;
   logic                pend_q, pend_d;
   logic                irq_q, irq_d;
   logic                tick_s;
   logic [31:0]         rd_s;
   logic                unused_wd;
`ifdef IRQ_TIMER_PRESCALE_EN
   logic [3:0]          ps_q, ps_d;
`endif

   // WD bits beyond the implemented register widths are don't-care
   assign unused_wd = ^WD;

`ifdef IRQ_TIMER_PRESCALE_EN
   assign tick_s = (ps_q == ctrl_q[7:4]);
`else
   assign tick_s = 1'b1;
`endif

   // Next-state: bus writes win over every FSM step in the same cycle
   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      pend_d   = pend_q;
`ifdef IRQ_TIMER_PRESCALE_EN
      ps_d     = ps_q;
`endif
      if (WE && (Addr == 2'd0)) begin
         ctrl_d  = WD[CTRL_W-1:0];
         pend_d  = 1'b0;
         state_d = ST_IDLE;
`ifdef IRQ_TIMER_PRESCALE_EN
         ps_d    = 4'd0;
`endif
      end else if (WE && (Addr == 2'd1)) begin
         preset_d = WD[COUNT_W-1:0];
         pend_d   = 1'b0;
         state_d  = ST_IDLE;
`ifdef IRQ_TIMER_PRESCALE_EN
         ps_d     = 4'd0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ctrl_q[0]) state_d = ST_LOAD;
               else           state_d = ST_IDLE;
            end
            ST_LOAD: begin
               count_d = preset_q;
               state_d = ST_CNT;
`ifdef IRQ_TIMER_PRESCALE_EN
               ps_d    = 4'd0;
`endif
            end
            ST_CNT: begin
               if (!ctrl_q[0]) begin
                  state_d = ST_IDLE;
               end else if (tick_s) begin
`ifdef IRQ_TIMER_PRESCALE_EN
                  ps_d = 4'd0;
`endif
                  // PRESET of 0 expires like 1 instead of wrapping
                  if (count_q > CNT_ONE) begin
                     count_d = count_q - CNT_ONE;
                  end else begin
                     count_d = CNT_ZERO;
                     pend_d  = 1'b1;
                     state_d = ST_INT;
                  end
               end else begin
`ifdef IRQ_TIMER_PRESCALE_EN
                  ps_d    = ps_q + 4'd1;
`else
                  state_d = ST_CNT;
`endif
               end
            end
            ST_INT: begin
               if (ctrl_q[2:1] == 2'b01) begin
                  pend_d  = 1'b0;
                  state_d = ST_LOAD;
               end else begin
                  ctrl_d[0] = 1'b0;
                  state_d   = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      irq_d = pend_d & ctrl_d[3];
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ctrl_q   <= {CTRL_W{1'b0}};
         preset_q <= CNT_ZERO;
         count_q  <= CNT_ZERO;
         pend_q   <= 1'b0;
         irq_q    <= 1'b0;
`ifdef IRQ_TIMER_PRESCALE_EN
         ps_q     <= 4'd0;
`endif
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
         irq_q    <= irq_d;
`ifdef IRQ_TIMER_PRESCALE_EN
         ps_q     <= ps_d;
`endif
      end
   end

   // Read mux shows pre-edge register contents
   always_comb begin
      rd_s = 32'd0;
      case (Addr)
         2'd0:    rd_s = 32'(ctrl_q);
         2'd1:    rd_s = 32'(preset_q);
         2'd2:    rd_s = 32'(count_q);
         default: rd_s = 32'd0;
      endcase
   end

   assign RD  = rd_s;
   assign IRQ = irq_q;

endmodule

// File: tb/tb_irq_timer.sv
// Directed bench for irq_timer: vector tables for one-shot, periodic and masked runs,
// plus hand-written sequences for EN clear, PRESET=0 and mid-count reset.
module tb_irq_timer;
   logic        clk;
   logic        rst;
   logic [1:0]  Addr;
   logic        WE;
   logic [31:0] WD;
   logic [31:0] RD;
   logic        IRQ;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        we;
      logic [1:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_irq;
      string       nm;
   } vec_t;

   vec_t tbl[$];

   irq_timer #(.COUNT_W(32)) dut (
      .clk  (clk),
      .rst  (rst),
      .Addr (Addr),
      .WE   (WE),
      .WD   (WD),
      .RD   (RD),
      .IRQ  (IRQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add(input logic we, input logic [1:0] a, input logic [31:0] d,
                               input logic [31:0] erd, input logic eirq, input string nm);
      vec_t v;
      v.we = we; v.addr = a; v.wd = d; v.exp_rd = erd; v.exp_irq = eirq; v.nm = nm;
      tbl.push_back(v);
   endfunction

   // Drive inputs mid low phase, compare pre-edge outputs, then take one clock edge
   task automatic step(input logic we, input logic [1:0] a, input logic [31:0] d,
                       input logic [31:0] erd, input logic eirq, input string nm);
      WE = we; Addr = a; WD = d;
      #1;
      n_checks++;
      if (RD !== erd) begin
         n_fail++;
         $display("FAIL %s RD: got %h, expected %h", nm, RD, erd);
      end
      n_checks++;
      if (IRQ !== eirq) begin
         n_fail++;
         $display("FAIL %s IRQ: got %b, expected %b", nm, IRQ, eirq);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string nm);
      for (int a = 0; a < 4; a++)
         step(1'b0, 2'(a), 32'd0, 32'd0, 1'b0, $sformatf("%s_a%0d", nm, a));
   endtask

   initial begin
      rst = 1'b1; WE = 1'b0; Addr = 2'd0; WD = 32'd0;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("reset");

      // One-shot, PRESET=5, CTRL=0x9 written at e0
      add(1'b1, 2'd1, 32'd5,    32'd0, 1'b0, "os_wr_preset");
      add(1'b1, 2'd0, 32'h9,    32'd0, 1'b0, "os_wr_ctrl");
      add(1'b0, 2'd2, 32'd0,    32'd0, 1'b0, "os_e0");
      add(1'b0, 2'd2, 32'd0,    32'd0, 1'b0, "os_e1");
      add(1'b0, 2'd2, 32'd0,    32'd5, 1'b0, "os_e2");
      add(1'b0, 2'd2, 32'd0,    32'd4, 1'b0, "os_e3");
      add(1'b0, 2'd2, 32'd0,    32'd3, 1'b0, "os_e4");
      add(1'b0, 2'd2, 32'd0,    32'd2, 1'b0, "os_e5");
      add(1'b0, 2'd2, 32'd0,    32'd1, 1'b0, "os_e6");
      add(1'b0, 2'd0, 32'd0,    32'h9, 1'b1, "os_e7");
      add(1'b0, 2'd0, 32'd0,    32'h8, 1'b1, "os_e8");
      add(1'b1, 2'd2, 32'h77,   32'd0, 1'b1, "os_wr_count_ign");
      add(1'b1, 2'd3, 32'h55,   32'd0, 1'b1, "os_wr_rsvd_ign");
      add(1'b0, 2'd2, 32'd0,    32'd0, 1'b1, "os_count_kept");
      add(1'b1, 2'd0, 32'h8,    32'h8, 1'b1, "os_clr_pend");
      add(1'b0, 2'd0, 32'd0,    32'h8, 1'b0, "os_irq_off");
      // Periodic, PRESET=3, CTRL=0xB
      add(1'b1, 2'd1, 32'd3,    32'd5, 1'b0, "p_wr_preset");
      add(1'b1, 2'd0, 32'hB,    32'h8, 1'b0, "p_wr_ctrl");
      add(1'b0, 2'd2, 32'd0,    32'd0, 1'b0, "p_e0");
      add(1'b0, 2'd2, 32'd0,    32'd0, 1'b0, "p_e1");
      add(1'b0, 2'd2, 32'd0,    32'd3, 1'b0, "p_e2");
      add(1'b0, 2'd2, 32'd0,    32'd2, 1'b0, "p_e3");
      add(1'b0, 2'd2, 32'd0,    32'd1, 1'b0, "p_e4");
      add(1'b0, 2'd2, 32'd0,    32'd0, 1'b1, "p_e5");
      add(1'b0, 2'd2, 32'd0,    32'd0, 1'b0, "p_e6");
      add(1'b0, 2'd2, 32'd0,    32'd3, 1'b0, "p_e7");
      add(1'b0, 2'd2, 32'd0,    32'd2, 1'b0, "p_e8");
      add(1'b0, 2'd2, 32'd0,    32'd1, 1'b0, "p_e9");
      add(1'b0, 2'd2, 32'd0,    32'd0, 1'b1, "p_e10");
      add(1'b0, 2'd0, 32'd0,    32'hB, 1'b0, "p_e11");
      add(1'b0, 2'd2, 32'd0,    32'd3, 1'b0, "p_e12");
      // Periodic with IM=0: same count sequence, IRQ suppressed
      add(1'b1, 2'd0, 32'h3,    32'hB, 1'b0, "m_wr_ctrl");
      add(1'b0, 2'd2, 32'd0,    32'd2, 1'b0, "m_e0");
      add(1'b0, 2'd2, 32'd0,    32'd2, 1'b0, "m_e1");
      add(1'b0, 2'd2, 32'd0,    32'd3, 1'b0, "m_e2");
      add(1'b0, 2'd2, 32'd0,    32'd2, 1'b0, "m_e3");
      add(1'b0, 2'd2, 32'd0,    32'd1, 1'b0, "m_e4");
      add(1'b0, 2'd2, 32'd0,    32'd0, 1'b0, "m_e5");
      add(1'b0, 2'd2, 32'd0,    32'd0, 1'b0, "m_e6");
      add(1'b0, 2'd2, 32'd0,    32'd3, 1'b0, "m_e7");
      add(1'b0, 2'd2, 32'd0,    32'd2, 1'b0, "m_e8");
      add(1'b0, 2'd2, 32'd0,    32'd1, 1'b0, "m_e9");
      add(1'b0, 2'd2, 32'd0,    32'd0, 1'b0, "m_e10");

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].exp_rd, tbl[i].exp_irq, tbl[i].nm);

      // EN cleared mid-count freezes COUNT; re-enable reloads PRESET
      step(1'b1, 2'd0, 32'h0,  32'h3, 1'b0, "fz_stop");
      step(1'b1, 2'd1, 32'd10, 32'd3, 1'b0, "fz_wr_preset");
      step(1'b1, 2'd0, 32'h9,  32'h0, 1'b0, "fz_wr_ctrl");
      for (int i = 0; i < 8; i++)
         step(1'b0, 2'd2, 32'd0, (i < 2) ? 32'd0 : 32'(12 - i), 1'b0, $sformatf("fz_e%0d", i));
      step(1'b1, 2'd0, 32'h8,  32'h9, 1'b0, "fz_clear_en");
      for (int i = 0; i < 3; i++)
         step(1'b0, 2'd2, 32'd0, 32'd4, 1'b0, $sformatf("fz_hold%0d", i));
      step(1'b1, 2'd0, 32'h9,  32'h8, 1'b0, "fz_reenable");
      step(1'b0, 2'd2, 32'd0,  32'd4, 1'b0, "fz_r0");
      step(1'b0, 2'd2, 32'd0,  32'd4, 1'b0, "fz_r1");
      step(1'b0, 2'd2, 32'd0,  32'd10, 1'b0, "fz_reload");

      // PRESET=0 expires like PRESET=1: IRQ after e3, no wrap
      step(1'b1, 2'd1, 32'd0,  32'd10, 1'b0, "z_wr_preset");
      step(1'b1, 2'd0, 32'h9,  32'h9, 1'b0, "z_wr_ctrl");
      step(1'b0, 2'd2, 32'd0,  32'd9, 1'b0, "z_e0");
      step(1'b0, 2'd2, 32'd0,  32'd9, 1'b0, "z_e1");
      step(1'b0, 2'd2, 32'd0,  32'd0, 1'b0, "z_e2");
      step(1'b0, 2'd2, 32'd0,  32'd0, 1'b1, "z_e3");
      step(1'b0, 2'd0, 32'd0,  32'h8, 1'b1, "z_e4");

      // Reset during CNT with a write pending on the bus
      step(1'b1, 2'd1, 32'd20, 32'd0, 1'b1, "r_wr_preset");
      step(1'b1, 2'd0, 32'hB,  32'h8, 1'b0, "r_wr_ctrl");
      step(1'b0, 2'd2, 32'd0,  32'd0, 1'b0, "r_e0");
      step(1'b0, 2'd2, 32'd0,  32'd0, 1'b0, "r_e1");
      step(1'b0, 2'd2, 32'd0,  32'd20, 1'b0, "r_e2");
      rst = 1'b1; WE = 1'b1; Addr = 2'd1; WD = 32'h55;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("midrst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/irq_timer.md
Name: irq_timer

Overview:
- Memory-mapped countdown timer acting as a hardware interrupt source for the CPU.
- Its IRQ output drives one bit of the CP0 HWInt[5:0] bus; the processor programs it through the bridge with word loads and stores.
- Supports one-shot (mode 0) and auto-reload periodic (mode 1) operation, with an interrupt mask bit.

Parameters:
COUNT_W, 32, width of PRESET and COUNT (2..32); upper read bits zero-filled.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
Addr  in  2  word offset (byte address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
WE  in  1  write enable for the addressed register
WD  in  32  write data
RD  out  32  combinational read data of the addressed register
IRQ  out  1  interrupt request to CP0 HWInt, level

Behaviour:
- Reset (rst high at a clk edge): CTRL=0, PRESET=0, COUNT=0, state=IDLE, pend=0; therefore IRQ=0 and RD=0 for every Addr.
- CTRL fields:
  - [0] EN, enable.
  - [2:1] MODE: 0 one-shot, 1 periodic, 2/3 behave as 0.
  - [3] IM, interrupt mask; 1 allows IRQ.
  - Other bits read 0.
- RD:
  - Addr 0: {28'b0, CTRL[3:0]}.
  - Addr 1: PRESET.
  - Addr 2: COUNT.
  - Addr 3: 0.
  - Always reflects the pre-edge register value, including in a write cycle.
- Writes:
  - WE & Addr=0: CTRL[3:0]<=WD[3:0], pend<=0, state<=IDLE.
  - WE & Addr=1: PRESET<=WD[COUNT_W-1:0], pend<=0, state<=IDLE.
  - Addr 2/3: ignored.
  - A register write has priority over every FSM action in the same cycle.
- IRQ = pend & CTRL.IM; registered, with no combinational path from inputs.
- FSM, one step per clk edge when no write occurs:
  - IDLE: EN=1 -> LOAD; otherwise stay.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT:
    - EN=0 -> IDLE, COUNT frozen.
    - COUNT>1 -> COUNT<=COUNT-1.
    - COUNT<=1 -> COUNT<=0, pend<=1 -> INT.
  - INT, mode 0: CTRL.EN<=0 -> IDLE; pend held until the next CTRL/PRESET write.
  - INT, mode 1: pend<=0 -> LOAD; IRQ is a 1-cycle pulse.
- Timing, with N=max(PRESET,1):
  - Write CTRL (EN=1) at edge e0 -> pend set at edge e0+N+2.
  - Mode 1 period is N+2 cycles, with IRQ high 1 cycle.
- PRESET=0 behaves exactly as PRESET=1; there is no wrap to 2^COUNT_W-1.
- Clearing EN mid-count (CTRL write) -> IDLE immediately. COUNT keeps its value; a re-enable reloads from PRESET.
- IM=0: pend still sets and the FSM sequence is unchanged; IRQ is suppressed. Setting IM later must write CTRL, which clears pend, so a masked expiry is lost by design.
- rst mid-operation: returns all state to reset values at that edge, regardless of WE.

Optional Feature:
IRQ_TIMER_PRESCALE_EN:
- Defined:
  - CTRL[7:4]=PS (read/write, readable at Addr 0).
  - Internal prescale counter; CNT decrements COUNT only on every (PS+1)-th cycle, so CNT dwell per COUNT value is PS+1 cycles.
  - Prescaler cleared on any write, on LOAD, and on rst.
  - PS=0 is identical to the undefined build.
- Undefined: CTRL[7:4] ignored on write and read as 0; COUNT decrements every CNT cycle.

Test Plan:
- rst -> IRQ=0; RD=0 at Addr 0,1,2,3.
- PRESET=5, CTRL=0x9 (EN, mode 0, IM) at e0 -> COUNT reads 5 after e2 and 1 after e6; IRQ=1 after e7; CTRL reads 0x8 after e8; IRQ stays 1 until CTRL write 0x8, then 0 the next cycle.
- PRESET=3, CTRL=0xB (mode 1) -> IRQ single-cycle pulses every 5 cycles, first after e5; COUNT reloads to 3.
- Same as above with CTRL=0x3 (IM=0) -> IRQ never asserts; COUNT still cycles 3,2,1,0 with period 5.
- Mode 0, PRESET=10; write CTRL=0x8 when COUNT=4 -> COUNT frozen at 4, no IRQ; rewrite CTRL=0x9 -> COUNT reloads 10.
- PRESET=0 with CTRL=0x9 -> IRQ after e3, same as PRESET=1; rst asserted during CNT -> all registers 0, IRQ 0 next cycle.
